// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and error decode for the data-memory responder
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                       we;
        logic [DMEM_ADDR_W-1:0]     addr;
        logic [DMEM_DATA_W-1:0]     wdata;
        logic [DMEM_DATA_W/8-1:0]   be;
    } req_t;

    // lsb = log2(bytes per word); misaligned or beyond the last word is an error
    function automatic logic is_err(input logic [63:0] addr, input logic [63:0] depth,
                                    input int lsb = 2);
        logic [63:0] mask;
        mask = (64'd1 << lsb) - 64'd1;
        return ((addr & mask) != 64'd0) || ((addr >> lsb) >= depth);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port RAM, synchronous read, per-byte write enable
module dmem_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // rdata_o only changes on a read so it holds across the response phase
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DATA_W / 8; b++) begin
                    if (be_i[b]) begin
                        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - cpu data-port responder; DMEM_STALL_EN adds a LATENCY-cycle wait
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o
);

    localparam int BE_W    = DATA_W / 8;
    localparam int LSB     = $clog2(BE_W);
    localparam int WORD_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state, state_nxt;
    req_t              live_req, cur_req;
    logic              accept, commit, cur_err;
    logic              err_q, load_q;
    logic [DATA_W-1:0] ram_rdata;

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        live_req       = '0;
        live_req.we    = req_we_i;
        live_req.addr  = DMEM_ADDR_W'(req_addr_i);
        live_req.wdata = DMEM_DATA_W'(req_wdata_i);
        live_req.be    = (DMEM_DATA_W/8)'(req_be_i);
    end

`ifdef DMEM_STALL_EN
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    logic [CNT_W-1:0] cnt;
    req_t             req_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt   <= '0;
            req_q <= '0;
        end else if (accept) begin
            cnt   <= CNT_W'(LATENCY - 1);
            req_q <= live_req;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // with LATENCY=1 the commit happens on the accept edge, straight from the port
    assign cur_req = (state == IDLE) ? live_req : req_q;
`else
    assign cur_req = live_req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DMEM_STALL_EN
                    state_nxt = (LATENCY > 1) ? WAIT : RESP;
`else
                    state_nxt = RESP;
`endif
                end
            end
`ifdef DMEM_STALL_EN
            WAIT: begin
                if (cnt == CNT_W'(1)) state_nxt = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // the RAM is touched only on the edge that enters RESP, and never under reset
    assign cur_err = is_err(64'(cur_req.addr), 64'(DEPTH_WORDS), LSB);
    assign commit  = ~reset_i & (state != RESP) & (state_nxt == RESP);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            err_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (commit) begin
                err_q  <= cur_err;
                load_q <= ~cur_req.we & ~cur_err;
            end
        end
    end

    dmem_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (WORD_AW)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (commit & ~cur_err),
        .we_i    (cur_req.we),
        .addr_i  (cur_req.addr[LSB +: WORD_AW]),
        .wdata_i (DATA_W'(cur_req.wdata)),
        .be_i    (BE_W'(cur_req.be)),
        .rdata_o (ram_rdata)
    );

    assign rsp_valid_o = (state == RESP);
    assign rsp_err_o   = (state == RESP) & err_q;
    assign rsp_rdata_o = (state == RESP && load_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int LAT = 4;
`ifdef DMEM_STALL_EN
    localparam int EXP_LAT = LAT;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [16];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    // Reference: a word array touched with plain byte arithmetic
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, output logic [31:0] rdata, output logic err);
        int unsigned word;
        word  = addr / 4;
        err   = (addr % 4 != 0) || (word >= 1024);
        rdata = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[word % 16][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rdata = mem_m[word % 16];
            end
        end
    endfunction

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output int lat, output logic [31:0] rdata,
                             output logic err, output logic rdy0, output logic vld0);
        @(negedge clk);
        rdy0 = req_ready;
        vld0 = rsp_valid;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_state got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        reset = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd, erd; logic er, eer, r0, v0;
        start_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er, r0, v0);
        model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        n_cmp++;
        if (r0 !== 1'b1) begin n_bad++; $display("FAIL store_ready got %b want 1", r0); end
        n_cmp++;
        if (lat !== EXP_LAT) begin n_bad++; $display("FAIL store_latency got %0d want %0d", lat, EXP_LAT); end
        n_cmp++;
        if ({er, rd} !== {eer, erd}) begin n_bad++; $display("FAIL store_rsp got err=%b rdata=%h want %b %h", er, rd, eer, erd); end
        finish_rsp();
        start_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, r0, v0);
        model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        n_cmp++;
        if ({er, rd} !== {1'b0, 32'hDEADBEEF} || erd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL load_full got err=%b rdata=%h want 0 deadbeef", er, rd);
        end
        n_cmp++;
        if (lat !== EXP_LAT) begin n_bad++; $display("FAIL load_latency got %0d want %0d", lat, EXP_LAT); end
        finish_rsp();
    endtask

    task automatic test_partial_store();
        int lat; logic [31:0] rd, erd; logic er, eer, r0, v0;
        start_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, rd, er, r0, v0);
        model(1'b1, 32'h10, 32'h000000AA, 4'b0001, erd, eer);
        finish_rsp();
        start_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, r0, v0);
        model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        n_cmp++;
        if ({er, rd} !== {1'b0, 32'hDEADBEAA}) begin n_bad++; $display("FAIL partial_store got %h want deadbeaa", rd); end
        finish_rsp();
        start_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, lat, rd, er, r0, v0);
        finish_rsp();
        start_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, r0, v0);
        n_cmp++;
        if ({er, rd} !== {1'b0, 32'hDEADBEAA}) begin n_bad++; $display("FAIL be_zero_noop got err=%b rdata=%h want 0 deadbeaa", er, rd); end
        finish_rsp();
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er, r0, v0;
        logic [31:0] bad_addr [3];
        bad_addr[0] = 32'h12; bad_addr[1] = 32'h1000; bad_addr[2] = 32'hFFFFFFFC;
        for (int i = 0; i < 3; i++) begin
            start_req(1'b0, bad_addr[i], 32'h0, 4'hF, lat, rd, er, r0, v0);
            n_cmp++;
            if ({er, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL err_load_%0d got err=%b rdata=%h want 1 0", i, er, rd); end
            finish_rsp();
        end
        start_req(1'b1, 32'h11, 32'h55555555, 4'hF, lat, rd, er, r0, v0);
        n_cmp++;
        if (er !== 1'b1) begin n_bad++; $display("FAIL err_store got err=%b want 1", er); end
        finish_rsp();
        start_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, r0, v0);
        n_cmp++;
        if ({er, rd} !== {1'b0, mem_m[4]}) begin n_bad++; $display("FAIL err_ram_unchanged got %h want %h", rd, mem_m[4]); end
        finish_rsp();
    endtask

    task automatic test_resp_hold();
        int lat; logic [31:0] rd, erd; logic er, eer, r0, v0;
        start_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, r0, v0);
        model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, erd}) begin
                n_bad++;
                $display("FAIL hold_%0d got vld=%b rdy=%b rdata=%h want 1 0 %h", i, rsp_valid, req_ready, rsp_rdata, erd);
            end
        end
        req_valid = 1'b0;
        finish_rsp();
        start_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, r0, v0);
        n_cmp++;
        if (rd !== erd) begin n_bad++; $display("FAIL hold_req_ignored got %h want %h", rd, erd); end
        finish_rsp();
    endtask

    task automatic test_reset_midflight();
        int lat; logic [31:0] rd, erd; logic er, eer, r0, v0;
        start_req(1'b1, 32'h20, 32'h11111111, 4'hF, lat, rd, er, r0, v0);
        model(1'b1, 32'h20, 32'h11111111, 4'hF, erd, eer);
        finish_rsp();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
`ifndef DMEM_STALL_EN
        model(1'b1, 32'h20, 32'h12345678, 4'hF, erd, eer);
`endif
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL midreset_state got rdy=%b vld=%b want 1 0", req_ready, rsp_valid); end
        reset = 1'b0;
        start_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, r0, v0);
        model(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        n_cmp++;
        if ({er, rd} !== {1'b0, erd}) begin n_bad++; $display("FAIL midreset_ram got %h want %h", rd, erd); end
        finish_rsp();
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, erd, addr, wd; logic er, eer, r0, v0, we; logic [3:0] be;
        for (int w = 0; w < 16; w++) begin
            if (w == 4 || w == 8) continue;
            wd = $urandom;
            start_req(1'b1, 32'(w * 4), wd, 4'hF, lat, rd, er, r0, v0);
            model(1'b1, 32'(w * 4), wd, 4'hF, erd, eer);
            finish_rsp();
        end
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1: addr = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFC : 32'(32'h1000 + 4 * $urandom_range(0, 1000));
                default: addr = 32'($urandom_range(0, 15) * 4);
            endcase
            we = 1'($urandom); wd = $urandom; be = 4'($urandom);
            start_req(we, addr, wd, be, lat, rd, er, r0, v0);
            model(we, addr, wd, be, erd, eer);
            n_cmp++;
            if ({lat == EXP_LAT, er, rd} !== {1'b1, eer, erd}) begin
                n_bad++;
                $display("FAIL rand_%0d we=%b addr=%h got lat=%0d err=%b rdata=%h want %0d %b %h",
                         i, we, addr, lat, er, rd, EXP_LAT, eer, erd);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_rsp();
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd, erd, wd; logic er, eer, r0, v0, we;
        for (int i = 0; i < 8; i++) begin
            we = i[0]; wd = $urandom;
            start_req(we, 32'h30, wd, 4'hF, lat, rd, er, r0, v0);
            model(we, 32'h30, wd, 4'hF, erd, eer);
            n_cmp++;
            if ({r0, v0, er, rd} !== {1'b1, 1'b0, eer, erd}) begin
                n_bad++;
                $display("FAIL b2b_%0d got rdy=%b vld=%b err=%b rdata=%h want 1 0 %b %h", i, r0, v0, er, rd, eer, erd);
            end
            finish_rsp();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_errors();
        test_resp_hold();
        test_reset_midflight();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
